// File: rtl/uart_pkg.sv
// Shared UART types and constants for the receive and transmit paths.
// Board-level defaults live here so both directions agree on the baud.
package uart_pkg;

  localparam int DATA_BITS        = 8;
  localparam int CLKS_PER_BIT_DEF = 868;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchronizer for async inputs; resets to the idle-high level.
// Used for Rx and other board inputs such as Switch.
module uart_rx_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= '1;
    else        ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver with a valid/ack holding register for the byte.
// Start bit is re-checked at mid-bit; data and stop are sampled mid-bit.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       CLK_100MHz,
  input  logic       Reset_n,
  input  logic       Rx,
  output logic [7:0] RxData,
  output logic       RxValid,
  input  logic       RxAck,
  output logic       FrameErr,
  output logic       Overrun,
  output logic       Busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST    = IW'(DATA_BITS - 1);

  rx_state_e            state;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 deliver;
  logic                 rx_s;

  uart_rx_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (CLK_100MHz),
    .rst_n(Reset_n),
    .d    (Rx),
    .q    (rx_s)
  );

  always_ff @(posedge CLK_100MHz or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shift_reg <= '0;
      deliver   <= 1'b0;
      RxData    <= '0;
      RxValid   <= 1'b0;
      FrameErr  <= 1'b0;
      Overrun   <= 1'b0;
      Busy      <= 1'b0;
    end else begin
      FrameErr <= 1'b0;
      Overrun  <= 1'b0;
      deliver  <= 1'b0;

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= '0;
            Busy  <= 1'b1;
          end
        end
        START: begin
          if (cnt == HALF_M1) begin
            cnt <= '0;
            idx <= '0;
            if (!rx_s) begin
              state <= DATA;
            end else begin
              state <= IDLE;
              Busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == FULL_M1) begin
            cnt       <= '0;
            shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
            if (idx == LAST) state <= STOP;
            else             idx   <= idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == FULL_M1) begin
            cnt <= '0;
            if (rx_s) begin
              deliver <= 1'b1;
              state   <= IDLE;
              Busy    <= 1'b0;
            end else begin
              FrameErr <= 1'b1;
              state    <= WAIT_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_IDLE: begin
          if (rx_s) begin
            state <= IDLE;
            Busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase

      // Same-cycle ack consumes the old byte, so no overrun in that case.
      if (deliver) begin
        RxData  <= shift_reg;
        RxValid <= 1'b1;
        Overrun <= RxValid && !RxAck;
      end else if (RxValid && RxAck) begin
        RxValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core at 16 clocks per bit.
module tb_uart_rx_core;

  localparam int BIT = 16;

  logic       clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       Rx = 1'b1;
  logic       RxAck = 1'b0;
  logic [7:0] RxData;
  logic       RxValid;
  logic       FrameErr;
  logic       Overrun;
  logic       Busy;

  int n_cmp = 0;
  int n_bad = 0;

  int cyc = 0;
  int start_cyc = 0;
  int ack_at = -100;
  bit auto_ack = 1'b0;

  int         rises = 0;
  int         rise_cyc = 0;
  logic       rise_busy = 1'b0;
  logic [7:0] rx_q[$];
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  int         busy_run = 0;
  int         busy_max = 0;
  logic       pv = 1'b0;

  uart_rx_core #(
    .CLKS_PER_BIT(BIT),
    .SYNC_STAGES (2)
  ) dut (
    .CLK_100MHz(clk),
    .Reset_n   (Reset_n),
    .Rx        (Rx),
    .RxData    (RxData),
    .RxValid   (RxValid),
    .RxAck     (RxAck),
    .FrameErr  (FrameErr),
    .Overrun   (Overrun),
    .Busy      (Busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (RxValid && !pv) begin
      rises++;
      rise_cyc  = cyc;
      rise_busy = Busy;
      rx_q.push_back(RxData);
      if (auto_ack) ack_at = cyc + 2;
    end
    pv = RxValid;
    if (FrameErr) fe_cnt++;
    if (Overrun)  ov_cnt++;
    if (Busy) busy_run++;
    else      busy_run = 0;
    if (busy_run > busy_max) busy_max = busy_run;
    RxAck = (cyc + 1 == ack_at);
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr();
    rises    = 0;
    rx_q.delete();
    fe_cnt   = 0;
    ov_cnt   = 0;
    busy_max = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int stop_cyc,
                           input logic stop_v);
    Rx        = 1'b0;
    start_cyc = cyc + 1;
    idle(BIT);
    for (int i = 0; i < 8; i++) begin
      Rx = b[i];
      idle(BIT);
    end
    Rx = stop_v;
    idle(stop_cyc);
    Rx = 1'b1;
  endtask

  function automatic logic [7:0] q_at(input int i);
    return (i < rx_q.size()) ? rx_q[i] : 8'hxx;
  endfunction

  initial begin
    idle(3);
    check("rst_data",  {24'd0, RxData}, 32'h00);
    check("rst_valid", {31'd0, RxValid}, 32'd0);
    check("rst_busy",  {31'd0, Busy}, 32'd0);
    check("rst_fe",    {31'd0, FrameErr}, 32'd0);
    check("rst_ov",    {31'd0, Overrun}, 32'd0);
    Reset_n = 1'b1;
    idle(5);

    // single byte, latency
    clr();
    send_byte(8'hA5, BIT, 1'b1);
    idle(4);
    check("a5_rises", rises, 1);
    check("a5_lat", rise_cyc - start_cyc, 155);
    check("a5_data", {24'd0, q_at(0)}, 32'hA5);
    check("a5_busy", {31'd0, rise_busy}, 32'd0);
    check("a5_fe", fe_cnt, 0);
    check("a5_ov", ov_cnt, 0);
    ack_at = cyc + 2;
    idle(4);
    check("a5_ackv", {31'd0, RxValid}, 32'd0);
    check("a5_hold", {24'd0, RxData}, 32'hA5);
    idle(5);

    // back-to-back with delayed ack
    clr();
    auto_ack = 1'b1;
    send_byte(8'h00, BIT, 1'b1);
    send_byte(8'hFF, BIT, 1'b1);
    idle(10);
    auto_ack = 1'b0;
    check("b2b_rises", rises, 2);
    check("b2b_d0", {24'd0, q_at(0)}, 32'h00);
    check("b2b_d1", {24'd0, q_at(1)}, 32'hFF);
    check("b2b_flags", fe_cnt + ov_cnt, 0);
    check("b2b_valid", {31'd0, RxValid}, 32'd0);

    // short start glitch
    clr();
    Rx = 1'b0;
    idle(5);
    Rx = 1'b1;
    idle(30);
    check("gl_rises", rises, 0);
    check("gl_flags", fe_cnt + ov_cnt, 0);
    check("gl_busy_seen", {31'd0, busy_max > 0}, 32'd1);
    check("gl_busy_max", {31'd0, busy_max <= 10}, 32'd1);
    check("gl_busy_end", {31'd0, Busy}, 32'd0);

    // framing error and break hold
    clr();
    send_byte(8'h3C, 3 * BIT, 1'b0);
    Rx = 1'b0;
    check("fe_cnt", fe_cnt, 1);
    check("fe_rises", rises, 0);
    check("fe_wait", {31'd0, Busy}, 32'd1);
    Rx = 1'b1;
    idle(5);
    check("fe_release", {31'd0, Busy}, 32'd0);
    send_byte(8'h12, BIT, 1'b1);
    idle(5);
    check("fe_next_rises", rises, 1);
    check("fe_next_data", {24'd0, q_at(0)}, 32'h12);
    check("fe_cnt_after", fe_cnt, 1);
    ack_at = cyc + 2;
    idle(5);

    // overrun without ack
    clr();
    send_byte(8'h11, BIT, 1'b1);
    send_byte(8'h22, BIT, 1'b1);
    idle(5);
    check("ov_cnt", ov_cnt, 1);
    check("ov_data", {24'd0, RxData}, 32'h22);
    check("ov_valid", {31'd0, RxValid}, 32'd1);
    check("ov_rises", rises, 1);
    ack_at = cyc + 2;
    idle(5);

    // ack on the delivery cycle
    clr();
    send_byte(8'h44, BIT, 1'b1);
    ack_at = cyc + 1 + 155;
    send_byte(8'h55, BIT, 1'b1);
    idle(5);
    check("ack_ov", ov_cnt, 0);
    check("ack_data", {24'd0, RxData}, 32'h55);
    check("ack_valid", {31'd0, RxValid}, 32'd1);

    // reset during data bit 4
    clr();
    Rx = 1'b0;
    idle(BIT);
    for (int i = 0; i < 4; i++) begin
      Rx = (8'h5A >> i) & 8'h01;
      idle(BIT);
    end
    Rx = 1'b1;
    idle(BIT / 2);
    Reset_n = 1'b0;
    idle(1);
    check("mr_data",  {24'd0, RxData}, 32'h00);
    check("mr_valid", {31'd0, RxValid}, 32'd0);
    check("mr_busy",  {31'd0, Busy}, 32'd0);
    check("mr_flags", {30'd0, FrameErr, Overrun}, 32'd0);
    idle(3);
    Reset_n = 1'b1;
    idle(BIT * 12);
    check("mr_nodeliv", rises, 0);
    send_byte(8'h77, BIT, 1'b1);
    idle(5);
    check("mr_rises", rises, 1);
    check("mr_data2", {24'd0, q_at(0)}, 32'h77);
    check("mr_flags2", fe_cnt + ov_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- Serial receiver for the board's UART link: the block that consumes the Rx line driven by the host/bench.
- Decodes 8N1 frames (1 start, 8 data LSB-first, 1 stop, no parity) into bytes.
- Presents each byte on a valid/ack holding interface to the demo logic (LED/seven-segment, loopback to the transmitter).
- Runs on the 100 MHz board clock; Rx is asynchronous to it.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per bit period (100 MHz / 115200); must be even and >= 8.
- SYNC_STAGES, 2, flip-flop stages in the Rx input synchronizer; must be >= 2.

Ports:
- CLK_100MHz  input  1  system clock; all logic on rising edge.
- Reset_n  input  1  asynchronous active-low reset.
- Rx  input  1  serial line; idles high.
- RxData  output  8  last accepted byte.
- RxValid  output  1  RxData holds an unconsumed byte.
- RxAck  input  1  consumer takes RxData this cycle; ignored when RxValid=0.
- FrameErr  output  1  one-cycle pulse: stop bit sampled low.
- Overrun  output  1  one-cycle pulse: a new byte overwrote an unconsumed one.
- Busy  output  1  high whenever the FSM is not IDLE.

Behaviour:
- Reset values: synchronizer all 1, FSM=IDLE, RxData=0x00, RxValid=0, FrameErr=0, Overrun=0, Busy=0, bit counter=0, bit index=0.
- Reset asserted mid-frame aborts the frame immediately. No byte is delivered and no flags are raised.
- rx_s is Rx after SYNC_STAGES flops. All decisions use rx_s only.
- IDLE: when rx_s==0, go to START and clear the counter.
- START:
  - Count to CLKS_PER_BIT/2-1, then sample rx_s.
  - Sample 0: go to DATA, counter=0, index=0.
  - Sample 1: treat as a glitch and return to IDLE. No flags.
- DATA:
  - Count to CLKS_PER_BIT-1, then sample and shift into shift_reg[7] (right-shift, LSB first).
  - After index 7, go to STOP.
- STOP: count to CLKS_PER_BIT-1, then sample.
  - Sample 1: deliver the byte (see below) and go to IDLE.
  - Sample 0: pulse FrameErr, do not deliver, go to WAIT_IDLE.
- WAIT_IDLE: stay until rx_s==1, then go to IDLE. This prevents re-triggering during a break condition.
- Delivery happens on the cycle after the stop sample: RxData<=shift_reg, RxValid<=1.
  - If RxValid was 1 and RxAck=0 that cycle, pulse Overrun and overwrite RxData.
  - If RxAck=1 in the same cycle as delivery, RxValid stays 1 with the new byte and there is no Overrun.
- RxAck with RxValid=1 and no delivery clears RxValid on the next edge. RxData is held.
- Latency: with SYNC_STAGES=2, RxValid rises exactly 9*CLKS_PER_BIT + CLKS_PER_BIT/2 + 3 clock edges after the first edge at which Rx is sampled low.
- Back-to-back frames: after delivery the FSM is in IDLE. It accepts a start edge arriving in the second half of the stop bit.
- Counter width is clog2(CLKS_PER_BIT). It wraps to 0 on every sample and never saturates.

Decomposition:
- Package uart_pkg holds:
  - state enum {IDLE, START, DATA, STOP, WAIT_IDLE};
  - DATA_BITS=8;
  - a default CLKS_PER_BIT constant shared with the transmitter.
- Sub-module uart_rx_sync: parameterised SYNC_STAGES flop chain with reset-to-1. It is reused by other async inputs (Switch).

Test Plan (CLKS_PER_BIT=16):
- Send 0xA5 at exact baud -> RxValid rises 155 edges after the start edge; RxData=0xA5; FrameErr=0; Overrun=0; Busy falls with delivery.
- Send 0x00 then 0xFF back-to-back, with RxAck pulsed 2 cycles after each RxValid -> two deliveries, 0x00 then 0xFF; RxValid low between them; no flags.
- Rx low for 5 cycles then high -> START aborts to IDLE; RxValid stays 0; no flags; Busy high for at most 8+2 cycles.
- Send 0x3C with the stop bit held low for 3 bit times -> one FrameErr pulse; RxValid stays 0; FSM holds WAIT_IDLE until Rx rises; a following 0x12 is received correctly.
- Send 0x11 then 0x22 with no RxAck -> one Overrun pulse at the second delivery; RxData=0x22; RxValid=1. Repeat with RxAck on the delivery cycle -> no Overrun.
- Assert Reset_n low during data bit 4 of 0x5A, release, then send 0x77 -> all outputs at reset values during reset; only 0x77 delivered.
